eeprom_ctrl: RTL

EEPROM_CTRL -- requirements
Module: eeprom_ctrl

---
 rtl/eeprom_ctrl_if.sv | 17 +
 rtl/eeprom_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/eeprom_ctrl_if.sv
// Host-side request/response bus of the parallel EEPROM controller.
// The host drives the request fields; the controller returns status and read data.
interface eeprom_ctrl_if;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;

    modport master (output req, wr, addr, wdata, input busy, done, rdata);
    modport slave  (input req, wr, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/eeprom_ctrl.sv
// Parallel EEPROM byte read/write sequencer with programmable strobe timing.
// All host and memory outputs are registered from the next-state decode.
module eeprom_ctrl #(
    parameter int unsigned RD_WAIT  = 3,
    parameter int unsigned WE_SETUP = 1,
    parameter int unsigned WE_PULSE = 4,
    parameter int unsigned WR_CYCLE = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    eeprom_ctrl_if.slave       host,
    output logic [12:0]        o_mem_a,
    output logic               o_mem_ce_n,
    output logic               o_mem_oe_n,
    output logic               o_mem_we_n,
    output logic [7:0]         o_mem_dout,
    output logic               o_mem_doe,
    input  logic [7:0]         i_mem_din
);
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ACCESS = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_PULSE  = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_WR_BUSY   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_done_nxt;
    logic           w_capture;
    logic           w_accept;
    logic           w_ce_n_nxt;
    logic           w_oe_n_nxt;
    logic           w_we_n_nxt;
    logic           w_doe_nxt;

    logic           r_busy;
    logic           r_done;
    logic [DW-1:0]  r_rdata;
    logic [AW-1:0]  r_mem_a;
    logic [DW-1:0]  r_mem_dout;
    logic           r_mem_doe;
    logic           r_mem_ce_n;
    logic           r_mem_oe_n;
    logic           r_mem_we_n;

    // Counter holds remaining cycles minus one; each phase ends when it reads zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_doe_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (host.req) begin
                    w_accept = 1'b1;
                    if (host.wr) begin
                        w_state_nxt = ST_WR_SETUP;
                        w_cnt_nxt   = CW'(WE_SETUP - 1);
                    end else begin
                        w_state_nxt = ST_RD_ACCESS;
                        w_cnt_nxt   = CW'(RD_WAIT - 1);
                    end
                end
            end
            ST_RD_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_WR_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WR_PULSE;
                    w_cnt_nxt   = CW'(WE_PULSE - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WR_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_WR_HOLD: begin
                w_state_nxt = ST_WR_BUSY;
                w_cnt_nxt   = CW'(WR_CYCLE - 1);
            end
            ST_WR_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Strobes are decoded from the state being entered so they register in step with it.
        case (w_state_nxt)
            ST_RD_ACCESS: begin
                w_ce_n_nxt = 1'b0;
                w_oe_n_nxt = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                w_ce_n_nxt = 1'b0;
                w_doe_nxt  = 1'b1;
            end
            ST_WR_PULSE: begin
                w_ce_n_nxt = 1'b0;
                w_we_n_nxt = 1'b0;
                w_doe_nxt  = 1'b1;
            end
            default: begin
                w_ce_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_doe  <= 1'b0;
            r_mem_ce_n <= 1'b1;
            r_mem_oe_n <= 1'b1;
            r_mem_we_n <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_mem_doe  <= w_doe_nxt;
            r_mem_ce_n <= w_ce_n_nxt;
            r_mem_oe_n <= w_oe_n_nxt;
            r_mem_we_n <= w_we_n_nxt;
            if (w_capture) begin
                r_rdata <= i_mem_din;
            end
            if (w_accept) begin
                r_mem_a <= host.addr;
                if (host.wr) begin
                    r_mem_dout <= host.wdata;
                end
            end
        end
    end

    assign host.busy  = r_busy;
    assign host.done  = r_done;
    assign host.rdata = r_rdata;
    assign o_mem_a    = r_mem_a;
    assign o_mem_dout = r_mem_dout;
    assign o_mem_doe  = r_mem_doe;
    assign o_mem_ce_n = r_mem_ce_n;
    assign o_mem_oe_n = r_mem_oe_n;
    assign o_mem_we_n = r_mem_we_n;
endmodule
